// File: rtl/door_controller.sv
// Elevator door controller: Moore FSM driving the door motors from
// limit switches, obstacle sensor, cabin requests and the timeout pulse.
module door_controller #(
  parameter int MOTION_MAX = 200,
  parameter int CNT_W      = 8,
  parameter int MAX_REOPEN = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       abrir,
  input  logic       cerrar,
  input  logic       obstaculo,
  input  logic       tope_abierto,
  input  logic       tope_cerrado,
  input  logic       timeout,
  output logic [1:0] estado,
  output logic       motor_abrir,
  output logic       motor_cerrar,
  output logic       cerrada,
  output logic       falla
);

  typedef enum logic [2:0] {
    CERRADA  = 3'd0,
    ABIERTA  = 3'd1,
    ABRIENDO = 3'd2,
    CERRANDO = 3'd3,
    FALLA    = 3'd4
  } state_t;

  state_t           st;
  state_t           nx;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       reo;
  logic             reo_inc;
  logic             stall;
  logic             reo_max;
  logic             moving;

  assign stall   = (cnt == CNT_W'(MOTION_MAX - 1));
  assign reo_max = (reo == 4'(MAX_REOPEN));
  assign moving  = (st == ABRIENDO) || (st == CERRANDO);

  always_comb begin
    nx      = st;
    reo_inc = 1'b0;
    unique case (st)
      CERRADA: begin
        if (abrir) nx = ABRIENDO;
      end
      ABRIENDO: begin
        if (tope_abierto) nx = ABIERTA;
        else if (stall)   nx = FALLA;
      end
      ABIERTA: begin
        if ((timeout | cerrar) & ~obstaculo & ~abrir)
          nx = CERRANDO;
      end
      CERRANDO: begin
        // a reopen request outranks both the limit switch and the stall
        if (obstaculo | abrir) begin
          if (reo_max) begin
            nx = FALLA;
          end else begin
            nx      = ABRIENDO;
            reo_inc = 1'b1;
          end
        end else if (tope_cerrado) begin
          nx = CERRADA;
        end else if (stall) begin
          nx = FALLA;
        end
      end
      default: nx = FALLA;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st  <= CERRANDO;
      cnt <= '0;
      reo <= '0;
    end else begin
      st <= nx;
      if (nx != st)   cnt <= '0;
      else if (moving) cnt <= cnt + 1'b1;
      if (st == CERRADA) reo <= '0;
      else if (reo_inc)  reo <= reo + 4'd1;
    end
  end

  always_comb begin
    estado       = 2'b00;
    motor_abrir  = 1'b0;
    motor_cerrar = 1'b0;
    cerrada      = 1'b0;
    falla        = 1'b0;
    unique case (st)
      CERRADA: begin
        estado  = 2'b00;
        cerrada = 1'b1;
      end
      ABIERTA: estado = 2'b01;
      ABRIENDO: begin
        estado      = 2'b10;
        motor_abrir = 1'b1;
      end
      CERRANDO: begin
        estado       = 2'b11;
        motor_cerrar = 1'b1;
      end
      default: begin
        estado = 2'b10;
        falla  = 1'b1;
      end
    endcase
  end

endmodule

// File: doc/door_controller.md
# door_controller

Elevator door controller FSM: drives the door motors from the cabin controller's open request, the limit switches, the obstacle sensor and the door-open timeout pulse. It is the producer of the 2-bit door `estado` bus that the timeout block watches, and the consumer of that block's `timeout` pulse, closing the loop between them. It also raises a sticky fault on motor stall or excessive re-openings, and a `cerrada` flag that permits cabin motion.

## Interface
- `MOTION_MAX`, default 200: maximum cycles allowed in ABRIENDO or CERRANDO before the stall fault; 1 ≤ MOTION_MAX < 2^CNT_W.
- `CNT_W`, default 8: width of the motion counter.
- `MAX_REOPEN`, default 3: re-openings allowed per close attempt sequence; range 0..15.
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `abrir`  in  1  open request / hold-open from the cabin controller (level).
- `cerrar`  in  1  close button (level).
- `obstaculo`  in  1  doorway obstacle sensor, 1 = blocked.
- `tope_abierto`  in  1  fully-open limit switch.
- `tope_cerrado`  in  1  fully-closed limit switch.
- `timeout`  in  1  one-cycle pulse from the timeout block.
- `estado`  out  2  door state: 00 CERRADA, 01 ABIERTA, 10 ABRIENDO, 11 CERRANDO.
- `motor_abrir`  out  1  open motor drive.
- `motor_cerrar`  out  1  close motor drive.
- `cerrada`  out  1  door closed and safe, cabin may move.
- `falla`  out  1  sticky fault.

## Operation
- The internal state is 3 bits: CERRADA, ABIERTA, ABRIENDO, CERRANDO, FALLA. All outputs decode from the state register (Moore).
- Output decode:
  - CERRADA: estado=00, cerrada=1, motors 0.
  - ABIERTA: estado=01, motors 0.
  - ABRIENDO: estado=10, motor_abrir=1.
  - CERRANDO: estado=11, motor_cerrar=1.
  - FALLA: estado=10, motors 0, falla=1, cerrada=0.
- Both motors are never 1 simultaneously.
- CERRADA:
  - abrir=1 → ABRIENDO.
  - Clears the reopen counter.
- ABRIENDO:
  - tope_abierto=1 → ABIERTA.
  - Else, on the MOTION_MAX-th cycle spent in the state → FALLA.
- ABIERTA: (timeout | cerrar) & !obstaculo & !abrir → CERRANDO. Otherwise stay.
  - A timeout pulse arriving while the condition is false is dropped.
  - The door then waits for the next pulse or for cerrar.
- CERRANDO, in priority order:
  1. obstaculo | abrir → if reopen counter == MAX_REOPEN then FALLA, else increment the counter and go to ABRIENDO.
  2. Else tope_cerrado → CERRADA.
  3. Else, on the MOTION_MAX-th cycle in the state → FALLA.
- FALLA is absorbing; only rst_n exits it.
- Motion counter:
  - Zeroed on every state change.
  - Increments each cycle in ABRIENDO/CERRANDO.
  - Stall is detected when the count reaches MOTION_MAX-1 with no limit switch.
  - A limit switch on that same cycle wins over the stall.
- Reset:
  - Forces state CERRANDO, both counters 0, falla=0.
  - So estado=11, motor_cerrar=1, cerrada=0 during and after reset. The door re-verifies closure through tope_cerrado.
  - Reset asserted mid-operation, including from FALLA, behaves identically.

## Timing
- Inputs are sampled on the rising edge of `clk`. The state and all outputs update on that same edge, giving one-cycle latency from input to output.
- CERRADA to ABRIENDO: abrir high at edge k → estado=10 and motor_abrir=1 after edge k.
- ABIERTA to CERRANDO: a timeout pulse at edge k → estado=11 after edge k.
- Stall: entry into ABRIENDO at edge e with no tope_abierto → state=FALLA after edge e+MOTION_MAX.
- Reset release: if tope_cerrado=1 at the first edge after release → CERRADA after that edge.
- Inputs are synchronous to `clk`. The timeout block output is registered and meets this requirement directly.

## Test plan
- Reset, then tope_cerrado=1 → CERRADA. Then abrir=1 for 1 cycle → estado=10. tope_abierto=1 at cycle 5 → estado=01, motors 0. timeout pulse → estado=11. tope_cerrado → estado=00, cerrada=1.
- In ABIERTA with obstaculo=1, pulse timeout → estado stays 01. Drop obstaculo, assert cerrar → estado=11 one cycle later.
- In CERRANDO, obstaculo pulses 3 times → three returns to ABRIENDO. The 4th pulse (MAX_REOPEN=3) → falla=1, estado=10, motors 0. abrir and cerrar are then ignored until rst_n low.
- ABRIENDO with no tope_abierto → FALLA exactly 200 cycles after entry. Repeat with tope_abierto asserted on cycle 200 → ABIERTA, falla=0.
- In CERRANDO, obstaculo and tope_cerrado rise on the same edge → ABRIENDO, reopen counter = 1.
- Assert rst_n=0 asynchronously mid-cycle while in ABIERTA → estado=11, motor_cerrar=1, falla=0 immediately, without waiting for a clock edge.
